// File: rtl/ik_swift_ctrl.sv
// Iteration controller for the ik_swift inverse-kinematics core: sequences clear/run/check
// passes, tracks the working DH parameter set and decides convergence from the core deltas.
module ik_swift_ctrl #(
   parameter int unsigned LATENCY = 40,
   parameter int unsigned ITER_W  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [ITER_W-1:0]            max_iter,
   input  logic [35:0]                  tolerance,
   input  logic [5:0][3:0][35:0]        dh_param_init,
   output logic                         core_en,
   output logic                         core_rst,
   output logic [5:0][3:0][35:0]        core_dh_param_in,
   input  logic [5:0][35:0]             core_delta,
   input  logic [5:0][3:0][35:0]        core_dh_param_out,
   output logic                         busy,
   output logic                         done,
   output logic                         converged,
   output logic [ITER_W-1:0]            iter_count,
   output logic [5:0][3:0][35:0]        dh_param_result
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StCheck,
      StDone
   } state_e;

   localparam logic [7:0]        LastCnt = 8'(LATENCY - 1);
   localparam logic [ITER_W-1:0] IterOne = {{(ITER_W-1){1'b0}}, 1'b1};

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [ITER_W-1:0]       iter_q, iter_d;
   logic [ITER_W-1:0]       max_q, max_d;
   logic [35:0]             tol_q, tol_d;
   logic                    conv_q, conv_d;
   logic [5:0][3:0][35:0]   param_q, param_d;

   logic [ITER_W-1:0]       iter_inc;
   logic                    within_tol;
   logic [35:0]             mag;

   assign iter_inc = iter_q + IterOne;

   // Two's-complement magnitude in 36 bits: the most negative value maps to 2^35.
   always_comb begin
      within_tol = 1'b1;
      mag        = '0;
      for (int i = 0; i < 6; i++) begin
         mag = core_delta[i][35] ? (~core_delta[i] + 36'd1) : core_delta[i];
         if (mag > tol_q) begin
            within_tol = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         iter_q  <= '0;
         max_q   <= '0;
         tol_q   <= '0;
         conv_q  <= 1'b0;
         param_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         max_q   <= max_d;
         tol_q   <= tol_d;
         conv_q  <= conv_d;
         param_q <= param_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      iter_d    = iter_q;
      max_d     = max_q;
      tol_d     = tol_q;
      conv_d    = conv_q;
      param_d   = param_q;
      core_en   = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            // abort is deliberately not looked at here: a coincident start wins.
            if (start) begin
               max_d   = max_iter;
               tol_d   = tolerance;
               param_d = dh_param_init;
               iter_d  = '0;
               conv_d  = 1'b0;
               state_d = (max_iter == '0) ? StDone : StClear;
            end
         end
         StClear: begin
            cnt_d   = '0;
            state_d = abort ? StDone : StRun;
         end
         StRun: begin
            core_en = 1'b1;
            if (abort) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == LastCnt) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            if (abort) begin
               state_d = StDone;
            end else begin
               param_d = core_dh_param_out;
               iter_d  = iter_inc;
               if (within_tol) begin
                  conv_d  = 1'b1;
                  state_d = StDone;
               end else if (iter_inc == max_q) begin
                  state_d = StDone;
               end else begin
                  state_d = StClear;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Reset is passed straight through so the core is held while the controller is.
   assign core_rst         = rst | (state_q == StClear);
   assign busy             = (state_q != StIdle);
   assign converged        = conv_q;
   assign iter_count       = iter_q;
   assign core_dh_param_in = param_q;
   assign dh_param_result  = param_q;

endmodule

// File: tb/tb_ik_swift_ctrl.sv
// Directed bench for ik_swift_ctrl with LATENCY=4; the core is modelled by fixed deltas and params.
module tb_ik_swift_ctrl;

   localparam int unsigned Lat    = 4;
   localparam int unsigned IterW  = 8;
   localparam int          Budget = 300;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       start = 1'b0;
   logic                       abort = 1'b0;
   logic [IterW-1:0]           max_iter = '0;
   logic [35:0]                tolerance = '0;
   logic [5:0][3:0][35:0]      dh_param_init = '0;
   logic                       core_en;
   logic                       core_rst;
   logic [5:0][3:0][35:0]      core_dh_param_in;
   logic [5:0][35:0]           core_delta = '0;
   logic [5:0][3:0][35:0]      core_dh_param_out = '0;
   logic                       busy;
   logic                       done;
   logic                       converged;
   logic [IterW-1:0]           iter_count;
   logic [5:0][3:0][35:0]      dh_param_result;

   int n_checks = 0;
   int n_pass   = 0;

   ik_swift_ctrl #(
      .LATENCY (Lat),
      .ITER_W  (IterW)
   ) u_dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .abort             (abort),
      .max_iter          (max_iter),
      .tolerance         (tolerance),
      .dh_param_init     (dh_param_init),
      .core_en           (core_en),
      .core_rst          (core_rst),
      .core_dh_param_in  (core_dh_param_in),
      .core_delta        (core_delta),
      .core_dh_param_out (core_dh_param_out),
      .busy              (busy),
      .done              (done),
      .converged         (converged),
      .iter_count        (iter_count),
      .dh_param_result   (dh_param_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [863:0] obs, input logic [863:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0][3:0][35:0] pattern(input int seed);
      logic [5:0][3:0][35:0] p;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 4; j++) begin
            p[i][j] = 36'h1_0000_0000 + 36'(seed * 256 + i * 16 + j);
         end
      end
      return p;
   endfunction

   function automatic logic [5:0][35:0] deltas(input logic [35:0] v);
      logic [5:0][35:0] d;
      for (int i = 0; i < 6; i++) begin
         d[i] = v;
      end
      return d;
   endfunction

   // Issues one start and reports edges from the sampling edge to done, CLEAR cycles seen
   // and whether core_en ever rose. Also confirms done is a single-cycle pulse.
   task automatic run_solve(input string tag, input logic [IterW-1:0] mi, input logic [35:0] tol,
                            input logic [5:0][3:0][35:0] init, input logic ab,
                            output int lat, output int clears, output logic en_seen);
      logic found;
      found   = 1'b0;
      lat     = -1;
      clears  = 0;
      en_seen = 1'b0;
      @(negedge clk);
      max_iter      = mi;
      tolerance     = tol;
      dh_param_init = init;
      start         = 1'b1;
      abort         = ab;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      for (int k = 0; k < Budget; k++) begin
         @(negedge clk);
         if (core_rst) clears++;
         if (core_en) en_seen = 1'b1;
         if (done) begin
            found = 1'b1;
            lat   = k;
            break;
         end
      end
      if (!found) begin
         check({tag, "_done_timeout"}, 864'(found), 864'(1));
      end else begin
         @(negedge clk);
         check({tag, "_done_pulse"}, 864'({done, busy}), 864'(0));
      end
   endtask

   int                    lat;
   int                    clears;
   logic                  en_seen;
   int                    done_seen;
   logic [5:0][3:0][35:0] p0, p1, p2;

   initial begin
      p0 = pattern(1);
      p1 = pattern(2);
      p2 = pattern(3);

      // Reset values while rst is held.
      #2;
      check("rst_busy",     864'(busy),            864'(0));
      check("rst_done",     864'(done),            864'(0));
      check("rst_conv",     864'(converged),       864'(0));
      check("rst_iter",     864'(iter_count),      864'(0));
      check("rst_param",    864'(dh_param_result), 864'(0));
      check("rst_core_en",  864'(core_en),         864'(0));
      check("rst_core_rst", 864'(core_rst),        864'(1));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_core_rst", 864'(core_rst), 864'(0));

      // Three non-converging iterations: 3*(4+2)=18 edges.
      core_delta        = deltas(36'd1);
      core_dh_param_out = p1;
      run_solve("maxit", 8'd3, 36'd0, p0, 1'b0, lat, clears, en_seen);
      check("maxit_lat",    864'(lat),        864'(18));
      check("maxit_conv",   864'(converged),  864'(0));
      check("maxit_iter",   864'(iter_count), 864'(3));
      check("maxit_clears", 864'(clears),     864'(3));

      // Converges on the first pass; start+abort together must still start.
      core_delta = deltas(36'd0);
      run_solve("conv", 8'd10, 36'd0, p0, 1'b1, lat, clears, en_seen);
      check("conv_lat",   864'(lat),             864'(6));
      check("conv_conv",  864'(converged),       864'(1));
      check("conv_iter",  864'(iter_count),      864'(1));
      check("conv_param", 864'(dh_param_result), 864'(p1));

      // Tolerance boundaries.
      core_delta    = deltas(36'd0);
      core_delta[5] = -36'sd5;
      run_solve("tol_neg5", 8'd1, 36'd5, p0, 1'b0, lat, clears, en_seen);
      check("tol_neg5_conv", 864'(converged), 864'(1));
      core_delta[5] = 36'd6;
      run_solve("tol_pos6", 8'd1, 36'd5, p0, 1'b0, lat, clears, en_seen);
      check("tol_pos6_conv", 864'(converged),  864'(0));
      check("tol_pos6_iter", 864'(iter_count), 864'(1));
      core_delta[5] = 36'h8_0000_0000;
      run_solve("tol_min", 8'd1, 36'h8_0000_0000, p0, 1'b0, lat, clears, en_seen);
      check("tol_min_conv", 864'(converged), 864'(1));
      core_delta[5] = 36'h8_0000_0000;
      run_solve("tol_min_m1", 8'd1, 36'h7_FFFF_FFFF, p0, 1'b0, lat, clears, en_seen);
      check("tol_min_m1_conv", 864'(converged), 864'(0));

      // max_iter=0: done in the cycle right after the sampling edge, core never enabled.
      run_solve("zero", 8'd0, 36'd0, p2, 1'b0, lat, clears, en_seen);
      check("zero_lat",  864'(lat),        864'(0));
      check("zero_iter", 864'(iter_count), 864'(0));
      check("zero_conv", 864'(converged),  864'(0));
      check("zero_en",   864'(en_seen),    864'(0));

      // Abort in RUN of iteration 2: edge 0 samples start, CHECK ends at edge 6, RUN from edge 7.
      core_delta        = deltas(36'd1);
      core_dh_param_out = p1;
      done_seen         = 0;
      @(negedge clk);
      max_iter      = 8'd5;
      tolerance     = 36'd0;
      dh_param_init = p0;
      start         = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         if (k == 0) check("abort_param_in", 864'(core_dh_param_in), 864'(p0));
         if (done && k < 9) done_seen++;
         if (k == 6) core_dh_param_out = p2;
         if (k == 8) begin
            check("abort_run_en", 864'(core_en), 864'(1));
            abort = 1'b1;
         end
         if (k == 9) begin
            abort = 1'b0;
            check("abort_done",  864'(done),            864'(1));
            check("abort_conv",  864'(converged),       864'(0));
            check("abort_iter",  864'(iter_count),      864'(1));
            check("abort_param", 864'(dh_param_result), 864'(p1));
         end
      end
      check("abort_early_done", 864'(done_seen), 864'(0));
      @(negedge clk);
      check("abort_idle", 864'(busy), 864'(0));

      // Reset mid-RUN, with start held high during reset.
      done_seen = 0;
      run_solve("pre_rst", 8'd1, 36'd0, p0, 1'b0, lat, clears, en_seen);
      @(negedge clk);
      max_iter = 8'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      #1;
      check("mrst_busy",     864'(busy),            864'(0));
      check("mrst_core_en",  864'(core_en),         864'(0));
      check("mrst_core_rst", 864'(core_rst),        864'(1));
      check("mrst_iter",     864'(iter_count),      864'(0));
      check("mrst_param",    864'(dh_param_result), 864'(0));
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("mrst_quiet", 864'(done_seen), 864'(0));
      core_delta = deltas(36'd0);
      run_solve("post_rst", 8'd4, 36'd0, p0, 1'b0, lat, clears, en_seen);
      check("post_rst_lat",  864'(lat),        864'(6));
      check("post_rst_conv", 864'(converged),  864'(1));
      check("post_rst_iter", 864'(iter_count), 864'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
